// File: rtl/rv_decode_pkg.sv
// Shared types for the decode queue: fetch entries, the decoded control bundle
// and the canonical NOP used whenever no real instruction is at the head.
package rv_decode_pkg;

    localparam logic [31:0] RV_NOP          = 32'h0000_0013;
    localparam bit          EXTENSION_Zicsr = 1'b1;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_ctrl_e;

    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4, RES_CSR} res_src_e;
    typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
    typedef enum logic       {OP2_RS2, OP2_IMM} op2_sel_e;
    typedef enum logic       {PC_REL, PC_RS1} pc_sel_e;
    typedef enum logic [1:0] {CSR_NONE, CSR_RW, CSR_RS, CSR_RC} csr_op_e;
    typedef enum logic       {CSR_SRC_RS1, CSR_SRC_UIMM} csr_sel_e;

    // Zicsr members are always present; they are tied off when the extension is disabled.
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        res_src_e    res_src;
        pc_sel_e     pc_sel;
        logic        jump;
        logic        branch;
        op1_sel_e    alu_op1_sel;
        op2_sel_e    alu_op2_sel;
        logic [2:0]  funct3;
        alu_ctrl_e   alu_ctrl;
        logic [11:0] csr_idx;
        csr_op_e     csr_op;
        csr_sel_e    csr_sel;
        logic        inv_instr;
    } dec_ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [29:0] pc;
        logic [29:0] pc_p4;
    } fetch_entry_t;

    function automatic alu_ctrl_e alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/core_decode.sv
// RV32I (+Zicsr) combinational instruction decoder. Illegal encodings raise
// inv_instr and have all architectural side effects cleared.
module core_decode
    import rv_decode_pkg::*;
(
    input  logic [31:0] instr,
    output dec_ctrl_t   dec
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec             = '0;
        dec.rs1         = instr[19:15];
        dec.rs2         = instr[24:20];
        dec.rd          = instr[11:7];
        dec.funct3      = f3;
        dec.csr_idx     = instr[31:20];
        dec.res_src     = RES_ALU;
        dec.pc_sel      = PC_REL;
        dec.alu_op1_sel = OP1_RS1;
        dec.alu_op2_sel = OP2_RS2;
        dec.alu_ctrl    = ALU_ADD;
        dec.csr_op      = CSR_NONE;
        dec.csr_sel     = CSR_SRC_RS1;

        case (opcode)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_from_funct(f3, f7[5]);
                if (!(f7 == 7'b0000000 ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
                    dec.inv_instr = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.reg_write   = 1'b1;
                dec.imm         = imm_i;
                dec.alu_op2_sel = OP2_IMM;
                // Only the shift-right immediate uses bit 30 to select arithmetic.
                dec.alu_ctrl    = alu_from_funct(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001 && f7 != 7'b0000000)
                    dec.inv_instr = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                    dec.inv_instr = 1'b1;
            end
            OPC_LOAD: begin
                dec.reg_write   = 1'b1;
                dec.mem_read    = 1'b1;
                dec.res_src     = RES_MEM;
                dec.imm         = imm_i;
                dec.alu_op2_sel = OP2_IMM;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                    dec.inv_instr = 1'b1;
            end
            OPC_STORE: begin
                dec.mem_write   = 1'b1;
                dec.imm         = imm_s;
                dec.alu_op2_sel = OP2_IMM;
                if (f3[2] || f3 == 3'b011)
                    dec.inv_instr = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch   = 1'b1;
                dec.imm      = imm_b;
                dec.alu_ctrl = (f3[2:1] == 2'b00) ? ALU_SUB :
                               (f3[1] ? ALU_SLTU : ALU_SLT);
                if (f3 == 3'b010 || f3 == 3'b011)
                    dec.inv_instr = 1'b1;
            end
            OPC_JAL: begin
                dec.jump        = 1'b1;
                dec.reg_write   = 1'b1;
                dec.res_src     = RES_PC4;
                dec.imm         = imm_j;
                dec.alu_op1_sel = OP1_PC;
                dec.alu_op2_sel = OP2_IMM;
            end
            OPC_JALR: begin
                dec.jump        = 1'b1;
                dec.reg_write   = 1'b1;
                dec.res_src     = RES_PC4;
                dec.pc_sel      = PC_RS1;
                dec.imm         = imm_i;
                dec.alu_op2_sel = OP2_IMM;
                if (f3 != 3'b000)
                    dec.inv_instr = 1'b1;
            end
            OPC_LUI: begin
                dec.reg_write   = 1'b1;
                dec.imm         = imm_u;
                dec.alu_op1_sel = OP1_ZERO;
                dec.alu_op2_sel = OP2_IMM;
            end
            OPC_AUIPC: begin
                dec.reg_write   = 1'b1;
                dec.imm         = imm_u;
                dec.alu_op1_sel = OP1_PC;
                dec.alu_op2_sel = OP2_IMM;
            end
            OPC_MISC_MEM: begin
                // FENCE is a no-op for an in-order single-issue core.
            end
            OPC_SYSTEM: begin
                // f3==0 (ecall/ebreak/xret) is resolved by execute from csr_idx.
                if (f3 == 3'b100) begin
                    dec.inv_instr = 1'b1;
                end else if (f3 != 3'b000) begin
                    if (EXTENSION_Zicsr) begin
                        dec.reg_write = 1'b1;
                        dec.res_src   = RES_CSR;
                        dec.csr_op    = csr_op_e'(f3[1:0]);
                        dec.csr_sel   = f3[2] ? CSR_SRC_UIMM : CSR_SRC_RS1;
                        dec.imm       = {27'b0, instr[19:15]};
                    end else begin
                        dec.inv_instr = 1'b1;
                    end
                end
            end
            default: dec.inv_instr = 1'b1;
        endcase

        if (dec.inv_instr) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.jump      = 1'b0;
            dec.branch    = 1'b0;
            dec.csr_op    = CSR_NONE;
        end
    end

endmodule

// File: rtl/rv_decode_queue.sv
// Decode stage: DEPTH-entry instruction queue between fetch and execute with an
// optional zero-latency bypass; the selected head entry feeds core_decode.
module rv_decode_queue
    import rv_decode_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [31:0]              i_instr,
    input  logic [29:0]              i_pc,
    input  logic [29:0]              i_pc_p4,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [29:0]              o_pc,
    output logic [29:0]              o_pc_p4,
    output dec_ctrl_t                o_dec,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem_reg [DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [CW-1:0]  count_next;

    fetch_entry_t   in_entry;
    fetch_entry_t   head_entry;
    fetch_entry_t   dec_entry;
    logic           empty;
    logic           full;
    logic           bypass_sel;
    logic           head_valid;
    logic           push;
    logic           pop;
    logic           wr_en;
    logic           rd_adv;

    assign in_entry   = '{instr: i_instr, pc: i_pc, pc_p4: i_pc_p4};
    assign empty      = (count_reg == '0);
    assign full       = (count_reg == CW'(DEPTH));
    assign o_in_ready = !full && !i_reset;

    assign bypass_sel = BYPASS && empty && i_in_valid;
    assign head_valid = !i_reset && !i_flush && (!empty || bypass_sel);

    assign push = i_in_valid && o_in_ready && !i_flush;
    assign pop  = head_valid && i_ready;

    // A bypassed entry that execute accepts immediately never touches storage.
    assign wr_en  = push && !(empty && pop);
    assign rd_adv = pop && !empty;

    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_adv})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (rd_adv)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem_reg[wr_ptr_reg] <= in_entry;
    end

    assign head_entry = empty ? in_entry : mem_reg[rd_ptr_reg];

    // Bubbles reach the decoder as a canonical NOP with a zero pc, never as stale data.
    assign dec_entry = head_valid ? head_entry
                                  : '{instr: RV_NOP, pc: 30'd0, pc_p4: 30'd0};

    core_decode u_core_decode (
        .instr (dec_entry.instr),
        .dec   (o_dec)
    );

    assign o_valid = head_valid;
    assign o_pc    = dec_entry.pc;
    assign o_pc_p4 = dec_entry.pc_p4;
    assign o_level = count_reg;

endmodule

// File: tb/tb_rv_decode_queue.sv
// Directed bench for rv_decode_queue: reset, bypass vs. non-bypass latency,
// fill/backpressure, illegal opcode, flush and wrapping push/pop streams.
module tb_rv_decode_queue;
    import rv_decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, ready;
    logic [31:0] instr;
    logic [29:0] pc, pc_p4;

    logic        in_ready, valid;
    logic [29:0] out_pc, out_pc_p4;
    dec_ctrl_t   dec;
    logic [1:0]  level;

    logic        nb_in_ready, nb_valid;
    logic [29:0] nb_pc, nb_pc_p4;
    dec_ctrl_t   nb_dec;
    logic [1:0]  nb_level;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_decode_queue #(.DEPTH(2), .BYPASS(1'b1)) dut (
        .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .i_instr(instr), .i_pc(pc), .i_pc_p4(pc_p4),
        .o_valid(valid), .i_ready(ready), .o_pc(out_pc), .o_pc_p4(out_pc_p4),
        .o_dec(dec), .o_level(level)
    );

    rv_decode_queue #(.DEPTH(2), .BYPASS(1'b0)) dut_nb (
        .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(nb_in_ready), .i_instr(instr), .i_pc(pc), .i_pc_p4(pc_p4),
        .o_valid(nb_valid), .i_ready(ready), .o_pc(nb_pc), .o_pc_p4(nb_pc_p4),
        .o_dec(nb_dec), .o_level(nb_level)
    );

    typedef struct {
        logic        flush;
        logic        iv;
        logic        rdy;
        logic [31:0] instr;
        logic [29:0] pc;
        logic        exp_valid;
        logic        exp_in_ready;
        logic [1:0]  exp_level;
        logic [29:0] exp_pc;
        logic        chk_dec;
        logic [4:0]  exp_rd;
        logic [31:0] exp_imm;
        logic        exp_inv;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [31:0] mk_addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'd0, rd, 7'h13};
    endfunction

    function automatic vec_t mk_vec(input logic f, input logic iv, input logic rdy,
                                    input logic [31:0] ins, input logic [29:0] p,
                                    input logic ev, input logic eir, input logic [1:0] el,
                                    input logic [29:0] ep, input logic cd, input logic [4:0] erd,
                                    input logic [31:0] eimm, input logic einv);
        vec_t v;
        v.flush = f; v.iv = iv; v.rdy = rdy; v.instr = ins; v.pc = p;
        v.exp_valid = ev; v.exp_in_ready = eir; v.exp_level = el; v.exp_pc = ep;
        v.chk_dec = cd; v.exp_rd = erd; v.exp_imm = eimm; v.exp_inv = einv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic iv, input logic rdy,
                         input logic [31:0] ins, input logic [29:0] p);
        flush    = f;
        in_valid = iv;
        ready    = rdy;
        instr    = ins;
        pc       = p;
        pc_p4    = p + 30'd1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dut(input string tag, input logic ev, input logic eir,
                             input logic [1:0] el, input logic [29:0] ep, input logic cd,
                             input logic [4:0] erd, input logic [31:0] eimm, input logic einv);
        chk({tag, ".valid"}, 32'(valid), 32'(ev));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(eir));
        chk({tag, ".level"}, 32'(level), 32'(el));
        chk({tag, ".pc"}, 32'(out_pc), 32'(ep));
        chk({tag, ".pc_p4"}, 32'(out_pc_p4), ev ? 32'(ep + 30'd1) : 32'd0);
        chk({tag, ".inv"}, 32'(dec.inv_instr), 32'(einv));
        if (cd) begin
            chk({tag, ".rd"}, 32'(dec.rd), 32'(erd));
            chk({tag, ".imm"}, dec.imm, eimm);
        end
        $display("%s: valid=%0b ready_in=%0b level=%0d pc=0x%0h rd=%0d imm=%0d inv=%0b",
                 tag, valid, in_ready, level, out_pc, dec.rd, dec.imm, dec.inv_instr);
    endtask

    initial begin
        logic [31:0] e1, e2, e3, e4, ill;
        e1  = mk_addi(5'd2, 12'd2);
        e2  = mk_addi(5'd3, 12'd3);
        e3  = mk_addi(5'd4, 12'd4);
        e4  = mk_addi(5'd5, 12'd7);
        ill = 32'hFFFF_FFFF;

        // Fill/backpressure, illegal opcode, flush; one row per cycle, checked before the edge.
        vecs[0]  = mk_vec(0,1,0, e1, 30'h10,  1,1,2'd0,30'h10, 1,5'd2,32'd2,0);
        vecs[1]  = mk_vec(0,1,0, e2, 30'h11,  1,1,2'd1,30'h10, 1,5'd2,32'd2,0);
        vecs[2]  = mk_vec(0,1,0, e3, 30'h12,  1,0,2'd2,30'h10, 1,5'd2,32'd2,0);
        vecs[3]  = mk_vec(0,1,1, e3, 30'h12,  1,0,2'd2,30'h10, 1,5'd2,32'd2,0);
        vecs[4]  = mk_vec(0,1,1, e3, 30'h12,  1,1,2'd1,30'h11, 1,5'd3,32'd3,0);
        vecs[5]  = mk_vec(0,0,1, 32'd0, 30'h0, 1,1,2'd1,30'h12, 1,5'd4,32'd4,0);
        vecs[6]  = mk_vec(0,0,1, 32'd0, 30'h0, 0,1,2'd0,30'h0,  1,5'd0,32'd0,0);
        vecs[7]  = mk_vec(0,1,0, ill, 30'h20, 1,1,2'd0,30'h20, 0,5'd0,32'd0,1);
        vecs[8]  = mk_vec(0,0,0, 32'd0, 30'h0, 1,1,2'd1,30'h20, 0,5'd0,32'd0,1);
        vecs[9]  = mk_vec(0,0,1, 32'd0, 30'h0, 1,1,2'd1,30'h20, 0,5'd0,32'd0,1);
        vecs[10] = mk_vec(0,0,1, 32'd0, 30'h0, 0,1,2'd0,30'h0,  1,5'd0,32'd0,0);
        vecs[11] = mk_vec(0,1,0, e1, 30'h10,  1,1,2'd0,30'h10, 1,5'd2,32'd2,0);
        vecs[12] = mk_vec(0,1,0, e2, 30'h11,  1,1,2'd1,30'h10, 1,5'd2,32'd2,0);
        vecs[13] = mk_vec(1,1,1, e3, 30'h12,  0,0,2'd2,30'h0,  1,5'd0,32'd0,0);
        vecs[14] = mk_vec(0,0,1, 32'd0, 30'h0, 0,1,2'd0,30'h0,  1,5'd0,32'd0,0);
        vecs[15] = mk_vec(0,1,1, e4, 30'h30,  1,1,2'd0,30'h30, 1,5'd5,32'd7,0);
        vecs[16] = mk_vec(0,0,1, 32'd0, 30'h0, 0,1,2'd0,30'h0,  1,5'd0,32'd0,0);

        // Reset held two cycles with fetch already presenting an entry.
        reset = 1'b1;
        drive(0, 1, 1, 32'h0050_0093, 30'h40);
        for (int c = 0; c < 2; c++) begin
            chk("reset.in_ready", 32'(in_ready), 32'd0);
            chk("reset.valid", 32'(valid), 32'd0);
            chk("reset.nb_valid", 32'(nb_valid), 32'd0);
            $display("reset cycle %0d: valid=%0b ready_in=%0b", c, valid, in_ready);
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 0, 32'd0, 30'h0);
        check_dut("post_reset", 0, 1, 2'd0, 30'h0, 1, 5'd0, 32'd0, 0);
        chk("post_reset.reg_write", 32'(dec.reg_write), 32'd1);
        chk("post_reset.alu_ctrl", 32'(dec.alu_ctrl), 32'(ALU_ADD));
        chk("post_reset.nb_in_ready", 32'(nb_in_ready), 32'd1);

        // Bypass: same-cycle on the BYPASS=1 instance, one cycle later without bypass.
        drive(0, 1, 1, 32'h0050_0093, 30'h40);
        check_dut("bypass", 1, 1, 2'd0, 30'h40, 1, 5'd1, 32'd5, 0);
        chk("bypass.nb_valid", 32'(nb_valid), 32'd0);
        tick();
        drive(0, 0, 1, 32'd0, 30'h0);
        check_dut("bypass_after", 0, 1, 2'd0, 30'h0, 1, 5'd0, 32'd0, 0);
        chk("nobypass.valid", 32'(nb_valid), 32'd1);
        chk("nobypass.level", 32'(nb_level), 32'd1);
        chk("nobypass.pc", 32'(nb_pc), 32'h40);
        chk("nobypass.pc_p4", 32'(nb_pc_p4), 32'h41);
        chk("nobypass.rd", 32'(nb_dec.rd), 32'd1);
        chk("nobypass.imm", nb_dec.imm, 32'd5);
        $display("nobypass: valid=%0b pc=0x%0h level=%0d", nb_valid, nb_pc, nb_level);
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].flush, vecs[i].iv, vecs[i].rdy, vecs[i].instr, vecs[i].pc);
            check_dut($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_in_ready,
                      vecs[i].exp_level, vecs[i].exp_pc, vecs[i].chk_dec,
                      vecs[i].exp_rd, vecs[i].exp_imm, vecs[i].exp_inv);
            tick();
        end

        // Streaming push+pop at level 1 across pointer wrap.
        drive(0, 1, 0, mk_addi(5'd1, 12'd0), 30'd0);
        check_dut("stream0", 1, 1, 2'd0, 30'd0, 1, 5'd1, 32'd0, 0);
        tick();
        for (int k = 1; k < 8; k++) begin
            drive(0, 1, 1, mk_addi(5'(k + 1), 12'(3 * k)), 30'(k));
            check_dut($sformatf("stream%0d", k), 1, 1, 2'd1, 30'(k - 1), 1,
                      5'(k), 32'(3 * (k - 1)), 0);
            tick();
        end
        drive(0, 0, 1, 32'd0, 30'h0);
        check_dut("stream_last", 1, 1, 2'd1, 30'd7, 1, 5'd8, 32'd21, 0);
        tick();
        drive(0, 0, 1, 32'd0, 30'h0);
        check_dut("stream_empty", 0, 1, 2'd0, 30'h0, 1, 5'd0, 32'd0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
